// File: rtl/nor_wb_sequencer_pkg.sv
// Shared types and NOR protocol constants for the NOR bus-cycle sequencer.
package nor_wb_sequencer_pkg;

  // Cycle codes carried in wb_adr_i[31:26]; any other value is illegal.
  typedef enum logic [5:0] {
    NOR_CYCLE_READ         = 6'h01,
    NOR_CYCLE_WRITE        = 6'h02,
    NOR_CYCLE_RESET        = 6'h03,
    NOR_CYCLE_PROGRAM      = 6'h04,
    NOR_CYCLE_ERASE_SECTOR = 6'h05,
    NOR_CYCLE_ERASE_CHIP   = 6'h06
  } nor_cycle_e;

  // JEDEC/AMD unlock addresses (word addresses) and command data bytes.
  localparam logic [11:0] NOR_UNLOCK_ADR1  = 12'h555;
  localparam logic [11:0] NOR_UNLOCK_ADR2  = 12'h2AA;
  localparam logic [11:0] NOR_RESET_ADR    = 12'h000;
  localparam logic [7:0]  NOR_DATA_UNLOCK1 = 8'hAA;
  localparam logic [7:0]  NOR_DATA_UNLOCK2 = 8'h55;
  localparam logic [7:0]  NOR_DATA_PROGRAM = 8'hA0;
  localparam logic [7:0]  NOR_DATA_ERASE   = 8'h80;
  localparam logic [7:0]  NOR_DATA_SECTOR  = 8'h30;
  localparam logic [7:0]  NOR_DATA_CHIP    = 8'h10;
  localparam logic [7:0]  NOR_DATA_RESET   = 8'hF0;

  // Longest sequence is six cycles, so a 3-bit step index is enough.
  localparam int STEP_W = 3;

  // Sequencer FSM states.
  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_NEXT,
    S_POLL_DLY,
    S_POLL,
    S_RESP
  } state_e;

  // Per-step control produced by the sequence ROM.
  typedef struct packed {
    logic valid;  // cycle code is legal
    logic we;     // 1 = write cycle
    logic last;   // final bus cycle of the sequence
    logic poll;   // sequence ends with ready/busy polling
  } step_ctl_t;

endpackage

// File: rtl/nor_wb_sequencer_if.sv
// Wishbone slave port plus NOR PHY request port of the sequencer.
interface nor_wb_sequencer_if #(
  parameter int ADDRBITS = 26,
  parameter int DATABITS = 16
);
  logic                wb_cyc_i;
  logic                wb_stb_i;
  logic                wb_we_i;
  logic [31:0]         wb_adr_i;
  logic [DATABITS-1:0] wb_dat_i;
  logic                wb_ack_o;
  logic                wb_err_o;
  logic                wb_stall_o;
  logic [DATABITS-1:0] wb_dat_o;
  logic                bus_req_o;
  logic                bus_we_o;
  logic [ADDRBITS-1:0] bus_adr_o;
  logic [DATABITS-1:0] bus_dat_o;
  logic                bus_ack_i;
  logic [DATABITS-1:0] bus_dat_i;

  // Sequencer side.
  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    output wb_ack_o, wb_err_o, wb_stall_o, wb_dat_o,
    output bus_req_o, bus_we_o, bus_adr_o, bus_dat_o,
    input  bus_ack_i, bus_dat_i
  );

  // Wishbone master / PHY side.
  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    input  wb_ack_o, wb_err_o, wb_stall_o, wb_dat_o,
    input  bus_req_o, bus_we_o, bus_adr_o, bus_dat_o,
    output bus_ack_i, bus_dat_i
  );
endinterface

// File: rtl/nor_seq_rom.sv
// Combinational sequence table: (cycle code, step) -> one NOR bus cycle.
// All knowledge of the unlock/command sequences lives here.
module nor_seq_rom
  import nor_wb_sequencer_pkg::*;
#(
  parameter int ADDRBITS = 26,
  parameter int DATABITS = 16
) (
  input  nor_cycle_e          cmd_i,
  input  logic [STEP_W-1:0]   step_i,
  input  logic [ADDRBITS-1:0] adr_i,
  input  logic [DATABITS-1:0] dat_i,
  output step_ctl_t           ctl_o,
  output logic [ADDRBITS-1:0] adr_o,
  output logic [DATABITS-1:0] dat_o
);

  localparam logic [ADDRBITS-1:0] A555 = ADDRBITS'(NOR_UNLOCK_ADR1);
  localparam logic [ADDRBITS-1:0] A2AA = ADDRBITS'(NOR_UNLOCK_ADR2);

  // Decode the current step of the requested sequence.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    ctl_o = '{valid: 1'b1, we: 1'b1, last: 1'b0, poll: 1'b0};
    adr_o = '0;
    dat_o = '0;
    case (cmd_i)
      NOR_CYCLE_READ: begin
        ctl_o.we   = 1'b0;
        ctl_o.last = 1'b1;
        adr_o      = adr_i;
      end
      NOR_CYCLE_WRITE: begin
        ctl_o.last = 1'b1;
        adr_o      = adr_i;
        dat_o      = dat_i;
      end
      NOR_CYCLE_RESET: begin
        ctl_o.last = 1'b1;
        adr_o      = ADDRBITS'(NOR_RESET_ADR);
        dat_o      = DATABITS'(NOR_DATA_RESET);
      end
      NOR_CYCLE_PROGRAM: begin
        case (step_i)
          3'd0: begin adr_o = A555; dat_o = DATABITS'(NOR_DATA_UNLOCK1); end
          3'd1: begin adr_o = A2AA; dat_o = DATABITS'(NOR_DATA_UNLOCK2); end
          3'd2: begin adr_o = A555; dat_o = DATABITS'(NOR_DATA_PROGRAM); end
          default: begin
            adr_o      = adr_i;
            dat_o      = dat_i;
            ctl_o.last = 1'b1;
            ctl_o.poll = 1'b1;
          end
        endcase
      end
      NOR_CYCLE_ERASE_SECTOR, NOR_CYCLE_ERASE_CHIP: begin
        case (step_i)
          3'd0: begin adr_o = A555; dat_o = DATABITS'(NOR_DATA_UNLOCK1); end
          3'd1: begin adr_o = A2AA; dat_o = DATABITS'(NOR_DATA_UNLOCK2); end
          3'd2: begin adr_o = A555; dat_o = DATABITS'(NOR_DATA_ERASE);   end
          3'd3: begin adr_o = A555; dat_o = DATABITS'(NOR_DATA_UNLOCK1); end
          3'd4: begin adr_o = A2AA; dat_o = DATABITS'(NOR_DATA_UNLOCK2); end
          default: begin
            ctl_o.last = 1'b1;
            ctl_o.poll = 1'b1;
            if (cmd_i == NOR_CYCLE_ERASE_CHIP) begin
              adr_o = A555;
              dat_o = DATABITS'(NOR_DATA_CHIP);
            end else begin
              adr_o = adr_i;
              dat_o = DATABITS'(NOR_DATA_SECTOR);
            end
          end
        endcase
      end
      default: begin
        ctl_o.valid = 1'b0;
        ctl_o.we    = 1'b0;
        ctl_o.last  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/sync2ps.sv
// Two-flop synchroniser with configurable reset value R.
module sync2ps #(
  parameter logic R = 1'b1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset_i) sync_q <= {2{R}};
    else         sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/nor_wb_sequencer.sv
// Wishbone slave that expands one NOR cycle-code request into the
// JEDEC/AMD bus-cycle sequence, issuing each cycle over a req/ack PHY link.
module nor_wb_sequencer
  import nor_wb_sequencer_pkg::*;
#(
  parameter int ADDRBITS     = 26,
  parameter int DATABITS     = 16,
  parameter int BUSY_START   = 8,
  parameter int BUSY_TIMEOUT = 2**24
) (
  input  logic                clk_i,
  input  logic                reset_i,
  nor_wb_sequencer_if.slave   io,
  input  logic                ry_by_i,
  output logic                busy_o
);

  localparam int              CNT_W        = 32;
  localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(BUSY_START - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  state_e              state_q, state_d;
  nor_cycle_e          cmd_q, cmd_d;
  logic [ADDRBITS-1:0] adr_q, adr_d;
  logic [DATABITS-1:0] dat_q, dat_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                req_q, req_d;
  logic                bwe_q, bwe_d;
  logic [ADDRBITS-1:0] badr_q, badr_d;
  logic [DATABITS-1:0] bdat_q, bdat_d;
  logic                last_q, last_d;
  logic                poll_q, poll_d;
  logic [DATABITS-1:0] rdata_q, rdata_d;
  logic [DATABITS-1:0] rd_q, rd_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;

  logic                ry_sync;
  logic                use_wb;
  logic                accept;
  logic                resp_en;
  logic                resp_ok;
  nor_cycle_e          rom_cmd;
  logic [STEP_W-1:0]   rom_step;
  logic [ADDRBITS-1:0] rom_adr;
  logic [DATABITS-1:0] rom_dat;
  step_ctl_t           rom_ctl;
  logic [ADDRBITS-1:0] rom_badr;
  logic [DATABITS-1:0] rom_bdat;

  // Direction always follows the cycle code, so the Wishbone WE bit is unused.
  logic unused_we;
  assign unused_we = io.wb_we_i;

  sync2ps #(.R(1'b1)) u_ry_sync (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .d_i    (ry_by_i),
    .q_o    (ry_sync)
  );

  // While free, the ROM looks at the incoming request so step 0 can be
  // loaded at accept; otherwise it looks at the latched request.
  always_comb begin
    use_wb   = (state_q == S_IDLE) || (state_q == S_RESP);
    accept   = io.wb_cyc_i && io.wb_stb_i && !busy_q;
    rom_cmd  = use_wb ? nor_cycle_e'(io.wb_adr_i[31:26]) : cmd_q;
    rom_step = use_wb ? '0 : step_q;
    rom_adr  = use_wb ? io.wb_adr_i[ADDRBITS-1:0] : adr_q;
    rom_dat  = use_wb ? io.wb_dat_i : dat_q;
  end

  nor_seq_rom #(.ADDRBITS(ADDRBITS), .DATABITS(DATABITS)) u_rom (
    .cmd_i (rom_cmd),
    .step_i(rom_step),
    .adr_i (rom_adr),
    .dat_i (rom_dat),
    .ctl_o (rom_ctl),
    .adr_o (rom_badr),
    .dat_o (rom_bdat)
  );

  // Next-state and next-output logic of the sequencer FSM.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    bwe_d   = bwe_q;
    badr_d  = badr_q;
    bdat_d  = bdat_q;
    last_d  = last_q;
    poll_d  = poll_q;
    rdata_d = rdata_q;
    rd_d    = rd_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    resp_en = 1'b0;
    resp_ok = 1'b0;

    case (state_q)
      S_IDLE, S_RESP: begin
        state_d = S_IDLE;
        if (accept) begin
          cmd_d  = rom_cmd;
          adr_d  = rom_adr;
          dat_d  = rom_dat;
          step_d = '0;
          if (rom_ctl.valid) begin
            req_d   = 1'b1;
            bwe_d   = rom_ctl.we;
            badr_d  = rom_badr;
            bdat_d  = rom_bdat;
            last_d  = rom_ctl.last;
            poll_d  = rom_ctl.poll;
            state_d = S_ISSUE;
          end else begin
            resp_en = 1'b1;
          end
        end
      end
      S_ISSUE, S_WAIT_ACK: begin
        state_d = S_WAIT_ACK;
        if (io.bus_ack_i) begin
          req_d   = 1'b0;
          rdata_d = io.bus_dat_i;
          step_d  = step_q + STEP_W'(1);
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (!last_q) begin
          req_d   = 1'b1;
          bwe_d   = rom_ctl.we;
          badr_d  = rom_badr;
          bdat_d  = rom_bdat;
          last_d  = rom_ctl.last;
          poll_d  = rom_ctl.poll;
          state_d = S_ISSUE;
        end else if (poll_q) begin
          cnt_d   = '0;
          state_d = S_POLL_DLY;
        end else begin
          resp_en = 1'b1;
          resp_ok = 1'b1;
        end
      end
      S_POLL_DLY: begin
        if (cnt_q >= START_LAST) begin
          cnt_d   = '0;
          state_d = S_POLL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_POLL: begin
        if (ry_sync) begin
          resp_en = 1'b1;
          resp_ok = 1'b1;
        end else if (cnt_q >= TIMEOUT_LAST) begin
          resp_en = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // An abandoned cycle still finishes on the NOR side but gets no response.
    if (resp_en) begin
      state_d = S_RESP;
      ack_d   = resp_ok && io.wb_cyc_i;
      err_d   = !resp_ok && io.wb_cyc_i;
      rd_d    = (cmd_d == NOR_CYCLE_READ) ? rdata_q : '0;
    end

    // The response cycle already counts as free so a new request can follow.
    busy_d = (state_d != S_IDLE) && (state_d != S_RESP);
  end

  // State and registered outputs; synchronous reset drops bus_req_o at once.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cmd_q   <= nor_cycle_e'('0);
      adr_q   <= '0;
      dat_q   <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      bwe_q   <= 1'b0;
      badr_q  <= '0;
      bdat_q  <= '0;
      last_q  <= 1'b0;
      poll_q  <= 1'b0;
      rdata_q <= '0;
      rd_q    <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      bwe_q   <= bwe_d;
      badr_q  <= badr_d;
      bdat_q  <= bdat_d;
      last_q  <= last_d;
      poll_q  <= poll_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign io.wb_ack_o   = ack_q;
  assign io.wb_err_o   = err_q;
  assign io.wb_stall_o = busy_q;
  assign io.wb_dat_o   = rd_q;
  assign io.bus_req_o  = req_q;
  assign io.bus_we_o   = bwe_q;
  assign io.bus_adr_o  = badr_q;
  assign io.bus_dat_o  = bdat_q;
  assign busy_o        = busy_q;

endmodule
